// File: rtl/pattern_detector_pkg.sv
// Shared types and helpers for the repeated-pattern detector.
package pattern_detector_pkg;

  localparam int unsigned PD_ARG_W = 32;

  typedef enum logic [1:0] {
    PD_IDLE  = 2'd0,
    PD_MATCH = 2'd1,
    PD_FOUND = 2'd2
  } pd_state_t;

  // Repeat target: a programmed count of zero still needs one full pattern.
  function automatic logic [PD_ARG_W-1:0] pd_target(input logic [PD_ARG_W-1:0] n);
    return (n == '0) ? PD_ARG_W'(1) : n;
  endfunction

endpackage

// File: rtl/pd_sym_select.sv
// Selects the expected symbol sym[idx] from the pattern and compares the
// incoming symbol against it and against sym0 (used for resynchronisation).
module pd_sym_select #(
  parameter int unsigned SYM_W   = 8,
  parameter int unsigned PAT_LEN = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [PAT_LEN*SYM_W-1:0] pattern,
  input  logic [IDX_W-1:0]         idx,
  input  logic [SYM_W-1:0]         data_in,
  output logic                     idx_hit_c,
  output logic                     sym0_hit_c
);

  logic [SYM_W-1:0] exp_sym;

  // Mux out the symbol at the current index.
  always_comb begin
    exp_sym = pattern[SYM_W-1:0];
    for (int i = 0; i < int'(PAT_LEN); i++) begin
      if (idx == IDX_W'(i)) exp_sym = pattern[i*SYM_W +: SYM_W];
    end
  end

  assign idx_hit_c  = (data_in == exp_sym);
  assign sym0_hit_c = (data_in == pattern[SYM_W-1:0]);

endmodule

// File: rtl/pattern_detector_gen.sv
// Detects N back-to-back repetitions of a programmable multi-symbol pattern.
module pattern_detector_gen
  import pattern_detector_pkg::*;
#(
  parameter int unsigned SYM_W   = 8,
  parameter int unsigned PAT_LEN = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         data_valid,
  input  logic [SYM_W-1:0]             data_in,
  input  logic [PAT_LEN*SYM_W-1:0]     pattern,
  input  logic [CNT_W-1:0]             n_repeats,
  output logic                         found_pulse,
  output logic                         found,
  output logic [CNT_W-1:0]             repeat_count,
  output logic [$clog2(PAT_LEN)-1:0]   sym_idx
);

  localparam int unsigned IDX_W  = $clog2(PAT_LEN);
  localparam int unsigned CNT1_W = CNT_W + 1;

  pd_state_t          state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               found_q, found_d;
  logic               pulse_q, pulse_d;

  logic               idx_hit_c;
  logic               sym0_hit_c;
  logic [CNT1_W-1:0]  cnt_inc;
  logic [CNT1_W-1:0]  target;
  logic [CNT_W-1:0]   cnt_sat;

  pd_sym_select #(
    .SYM_W   (SYM_W),
    .PAT_LEN (PAT_LEN),
    .IDX_W   (IDX_W)
  ) u_sel (
    .pattern    (pattern),
    .idx        (idx_q),
    .data_in    (data_in),
    .idx_hit_c  (idx_hit_c),
    .sym0_hit_c (sym0_hit_c)
  );

  // Repeat arithmetic at CNT_W+1 bits; the stored count saturates instead of wrapping.
  assign cnt_inc = CNT1_W'(cnt_q) + CNT1_W'(1);
  assign target  = CNT1_W'(pd_target(PD_ARG_W'(n_repeats)));
  assign cnt_sat = cnt_inc[CNT_W] ? {CNT_W{1'b1}} : cnt_inc[CNT_W-1:0];

  // State, index and count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= PD_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      found_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      found_q <= found_d;
      pulse_q <= pulse_d;
    end
  end

  // Next-state logic; clr wins over an accepted symbol, idle cycles hold everything.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    found_d = found_q;
    pulse_d = 1'b0;
    if (clr) begin
      state_d = PD_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
      found_d = 1'b0;
    end else if (data_valid) begin
      case (state_q)
        PD_IDLE: begin
          if (sym0_hit_c) begin
            state_d = PD_MATCH;
            idx_d   = IDX_W'(1);
            cnt_d   = '0;
          end
        end
        PD_MATCH: begin
          if (idx_hit_c) begin
            if (idx_q == IDX_W'(PAT_LEN - 1)) begin
              idx_d = '0;
              cnt_d = cnt_sat;
              if (cnt_inc >= target) begin
                state_d = PD_FOUND;
                found_d = 1'b1;
                pulse_d = 1'b1;
              end
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            cnt_d = '0;
            if (sym0_hit_c) begin
              idx_d = IDX_W'(1);
            end else begin
              state_d = PD_IDLE;
              idx_d   = '0;
            end
          end
        end
        PD_FOUND: begin
        end
        default: begin
          state_d = PD_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign found_pulse  = pulse_q;
  assign found        = found_q;
  assign repeat_count = cnt_q;
  assign sym_idx      = idx_q;

endmodule
